pq_req_sched: RTL and testbench

Request scheduler that sits directly upstream of the register-array priority queue (PQ) and serialises client traffic into one PQ command per cycle. It decouples clients from the PQ with valid/ready handshakes:
- an enqueue channel buffered by a small FIFO;
- a dequeue request channel;
- a registered result channel.

It fuses a pending enqueue with a pending dequeue into a single `replace` command, never issues illegal commands against PQ full/empty, and supports a flush that drains everything to the result port.

---
 rtl/pq_pkg.sv | 20 ++
 rtl/pq_req_sched_if.sv | 37 +++
 rtl/pq_in_fifo.sv | 59 +++++
 rtl/pq_req_sched.sv | 106 ++++++++++
 tb/tb_pq_req_sched.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pq_pkg.sv
// pq_pkg: shared types for the priority-queue request scheduler.
//   KEY_WIDTH / VAL_WIDTH : field widths of one queue entry
//   kv_t                  : {key, val} entry as carried on every data port
//   pq_cmd_t              : command issued to the priority queue each cycle
//   sched_state_t         : scheduler FSM states
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {CMD_NONE, CMD_ENQ, CMD_DEQ, CMD_REPL} pq_cmd_t;

  typedef enum logic {ST_RUN, ST_FLUSH} sched_state_t;

endpackage

// File: rtl/pq_req_sched_if.sv
// pq_req_sched_if: client channels and PQ command port of the scheduler.
//   enq_*   : enqueue request channel (valid/ready), data enq_kv
//   deq_*   : dequeue request channel (valid/ready)
//   res_*   : registered result channel (valid/ready), data res_kv
//   flush / flush_done : flush start pulse and completion pulse
//   pq_*    : command/data to the PQ and its status/top back
// master = client + PQ side, slave = scheduler side.
interface pq_req_sched_if;
  import pq_pkg::*;

  logic    enq_valid;
  kv_t     enq_kv;
  logic    enq_ready;
  logic    deq_valid;
  logic    deq_ready;
  logic    res_valid;
  kv_t     res_kv;
  logic    res_ready;
  logic    flush;
  logic    flush_done;
  pq_cmd_t pq_cmd;
  kv_t     pq_kvi;
  kv_t     pq_kvo;
  logic    pq_full;
  logic    pq_empty;

  modport master (
    output enq_valid, enq_kv, deq_valid, res_ready, flush, pq_kvo, pq_full, pq_empty,
    input  enq_ready, deq_ready, res_valid, res_kv, flush_done, pq_cmd, pq_kvi
  );

  modport slave (
    input  enq_valid, enq_kv, deq_valid, res_ready, flush, pq_kvo, pq_full, pq_empty,
    output enq_ready, deq_ready, res_valid, res_kv, flush_done, pq_cmd, pq_kvi
  );

endinterface

// File: rtl/pq_in_fifo.sv
// pq_in_fifo: small synchronous FIFO buffering enqueue requests.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents)
//   push, din  : write din when not full
//   pop        : drop the head when not empty
//   dout       : current head entry
//   full/empty : occupancy flags
module pq_in_fifo
  import pq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  kv_t  din,
  output kv_t  dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  kv_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign dout    = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pq_req_sched.sv
// pq_req_sched: serialises client enqueue/dequeue traffic into one PQ
// command per cycle, fusing a pending enqueue and dequeue into REPL, and
// draining everything to the result port on flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pq_req_sched_if.slave (client channels + PQ port)
module pq_req_sched
  import pq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  pq_req_sched_if.slave bus
);

  sched_state_t state_q;
  sched_state_t state_d;
  pq_cmd_t      cmd;
  logic         flush_done_c;
  logic         f_full;
  logic         f_empty;
  logic         f_ne;
  logic         f_push;
  kv_t          f_head;
  logic         slot_free;
  logic         issue_pop;
  logic         issue_res;
  logic         res_valid_q;
  kv_t          res_kv_q;

  // The result slot can take a new item if empty or being drained now.
  assign slot_free = !res_valid_q || bus.res_ready;
  assign f_ne      = !f_empty;
  assign issue_pop = (cmd == CMD_ENQ) || (cmd == CMD_REPL);
  assign issue_res = (cmd == CMD_DEQ) || (cmd == CMD_REPL);

  // rst_n gates enq_ready so the client sees it low throughout reset.
  assign bus.enq_ready = rst_n && (state_q == ST_RUN) && !f_full;
  assign f_push        = bus.enq_valid && bus.enq_ready;

  pq_in_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .pop   (issue_pop),
    .din   (bus.enq_kv),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // In FLUSH the FIFO head is pushed through the PQ (REPL when a result
  // slot is free, plain ENQ when the PQ is empty) so the output sequence
  // is the PQ's ordering of everything held. Commands are suppressed in
  // reset because the PQ still samples at clock edges.
  always_comb begin
    state_d      = state_q;
    cmd          = CMD_NONE;
    flush_done_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (f_ne && bus.deq_valid && !bus.pq_empty && slot_free) cmd = CMD_REPL;
        else if (bus.deq_valid && !bus.pq_empty && slot_free)   cmd = CMD_DEQ;
        else if (f_ne && !bus.pq_full)                          cmd = CMD_ENQ;
        if (bus.flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (f_ne && !bus.pq_empty && slot_free)       cmd = CMD_REPL;
        else if (f_ne && bus.pq_empty)                cmd = CMD_ENQ;
        else if (!f_ne && !bus.pq_empty && slot_free) cmd = CMD_DEQ;
        if (f_empty && bus.pq_empty) begin
          state_d      = ST_RUN;
          flush_done_c = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst_n) cmd = CMD_NONE;
  end

  assign bus.pq_cmd     = cmd;
  assign bus.pq_kvi     = issue_pop ? f_head : '0;
  assign bus.deq_ready  = (state_q == ST_RUN) && issue_res;
  assign bus.flush_done = flush_done_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_kv     = res_kv_q;

  // A reload in the same cycle as res_ready keeps res_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_kv_q    <= '0;
    end else if (issue_res) begin
      res_valid_q <= 1'b1;
      res_kv_q    <= bus.pq_kvo;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pq_req_sched.sv
// tb_pq_req_sched: drives the scheduler against a depth-4 max-key PQ model
// and compares every cycle with a queue-based reference of the scheduler.
module tb_pq_req_sched;
  import pq_pkg::*;

  localparam int DEPTH = 4;
  localparam int PQ_DEPTH = 4;

  logic clk;
  logic rst_n;
  pq_req_sched_if bus ();

  pq_req_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference state: client FIFO contents, flush mode, result register.
  kv_t fq[$];
  kv_t pq[$];
  bit  m_flush;
  bit  m_rv;
  kv_t m_rk;

  pq_cmd_t e_cmd;
  kv_t     e_kvi;
  bit      e_enq_ready;
  bit      e_deq_ready;
  bit      e_fd;

  typedef struct {
    bit         ev;
    logic [7:0] ek;
    bit         dv;
    bit         rr;
    pq_cmd_t    cmd;
    logic [7:0] kvi;
    bit         enq_rdy;
    bit         deq_rdy;
    bit         rv;
    logic [7:0] rkey;
  } vec_t;

  vec_t tbl[11];
  logic [7:0] got[$];
  int fd_count;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pqTopIdx();
    int best = 0;
    for (int i = 1; i < pq.size(); i++)
      if (pq[i].key > pq[best].key) best = i;
    return best;
  endfunction

  function automatic kv_t pqTop();
    if (pq.size() == 0) return '0;
    return pq[pqTopIdx()];
  endfunction

  task automatic pqDrive();
    bus.pq_kvo   = pqTop();
    bus.pq_full  = (pq.size() >= PQ_DEPTH);
    bus.pq_empty = (pq.size() == 0);
  endtask

  // Expected command and handshake outputs from the rule tables.
  task automatic predict();
    bit slot, fne, pe, pf;
    slot = !m_rv || bus.res_ready;
    fne  = fq.size() != 0;
    pe   = pq.size() == 0;
    pf   = pq.size() >= PQ_DEPTH;
    e_cmd = CMD_NONE;
    if (!m_flush) begin
      if (fne && bus.deq_valid && !pe && slot) e_cmd = CMD_REPL;
      else if (bus.deq_valid && !pe && slot)   e_cmd = CMD_DEQ;
      else if (fne && !pf)                     e_cmd = CMD_ENQ;
    end else begin
      if (fne && !pe && slot)       e_cmd = CMD_REPL;
      else if (fne && pe)           e_cmd = CMD_ENQ;
      else if (!fne && !pe && slot) e_cmd = CMD_DEQ;
    end
    e_kvi       = (e_cmd == CMD_ENQ || e_cmd == CMD_REPL) ? fq[0] : '0;
    e_enq_ready = !m_flush && (fq.size() < DEPTH);
    e_deq_ready = !m_flush && (e_cmd == CMD_DEQ || e_cmd == CMD_REPL);
    e_fd        = m_flush && !fne && pe;
  endtask

  task automatic applyStimulus(input bit ev, input logic [7:0] ek, input bit dv,
                               input bit rr, input bit fl);
    bus.enq_valid = ev;
    bus.enq_kv    = {ek, 8'($urandom)};
    bus.deq_valid = dv;
    bus.res_ready = rr;
    bus.flush     = fl;
    #1;
    predict();
  endtask

  task automatic checkOutput();
    check("pq_cmd", int'(bus.pq_cmd), int'(e_cmd));
    check("pq_kvi", int'(bus.pq_kvi), int'(e_kvi));
    check("enq_ready", int'(bus.enq_ready), int'(e_enq_ready));
    check("deq_ready", int'(bus.deq_ready), int'(e_deq_ready));
    check("res_valid", int'(bus.res_valid), int'(m_rv));
    if (m_rv) check("res_kv", int'(bus.res_kv), int'(m_rk));
    check("flush_done", int'(bus.flush_done), int'(e_fd));
  endtask

  // Advance one clock; the PQ model follows the DUT's actual command.
  task automatic clockEdge();
    pq_cmd_t c;
    kv_t     k, top, ekv;
    bit      push;
    c    = bus.pq_cmd;
    k    = bus.pq_kvi;
    top  = pqTop();
    ekv  = bus.enq_kv;
    push = bus.enq_valid && e_enq_ready;
    @(posedge clk);
    #1;
    if ((e_cmd == CMD_ENQ || e_cmd == CMD_REPL) && fq.size() > 0) void'(fq.pop_front());
    if (push) fq.push_back(ekv);
    if (e_cmd == CMD_DEQ || e_cmd == CMD_REPL) begin
      m_rv = 1'b1;
      m_rk = top;
    end else if (bus.res_ready) begin
      m_rv = 1'b0;
    end
    if (!m_flush && bus.flush) m_flush = 1'b1;
    else if (m_flush && e_fd)  m_flush = 1'b0;
    if ((c == CMD_DEQ || c == CMD_REPL) && pq.size() > 0) pq.delete(pqTopIdx());
    if ((c == CMD_ENQ || c == CMD_REPL) && pq.size() < PQ_DEPTH) pq.push_back(k);
    pqDrive();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input bit ev, input logic [7:0] ek, input bit dv,
                     input bit rr, input bit fl);
    applyStimulus(ev, ek, dv, rr, fl);
    checkOutput();
  endtask

  // Reset with requests active; the PQ keeps its contents until release
  // so an ungated DEQ during reset would be visible.
  task automatic resetDut();
    rst_n = 1'b0;
    bus.enq_valid = 1'b1;
    bus.enq_kv    = {8'($urandom), 8'($urandom)};
    bus.deq_valid = 1'b1;
    bus.res_ready = 1'b1;
    bus.flush     = 1'b0;
    fq.delete();
    m_flush = 1'b0;
    m_rv    = 1'b0;
    m_rk    = '0;
    #1;
    check("rst_cmd", int'(bus.pq_cmd), int'(CMD_NONE));
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_kv", int'(bus.res_kv), 0);
    check("rst_enq_ready", int'(bus.enq_ready), 0);
    check("rst_deq_ready", int'(bus.deq_ready), 0);
    check("rst_kvi", int'(bus.pq_kvi), 0);
    check("rst_flush_done", int'(bus.flush_done), 0);
    @(negedge clk);
    check("rst_cmd_hold", int'(bus.pq_cmd), int'(CMD_NONE));
    check("rst_res_valid_hold", int'(bus.res_valid), 0);
    pq.delete();
    pqDrive();
    bus.enq_valid = 1'b0;
    bus.deq_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_kv    = '0;
    bus.deq_valid = 1'b0;
    bus.res_ready = 1'b1;
    bus.flush     = 1'b0;
    pqDrive();

    tbl[0]  = '{1'b1, 8'd8,  1'b0, 1'b1, CMD_NONE, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 8'd11, 1'b0, 1'b1, CMD_ENQ,  8'd8,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 8'd9,  1'b0, 1'b1, CMD_ENQ,  8'd11, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 8'd10, 1'b0, 1'b1, CMD_ENQ,  8'd9,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 8'd0,  1'b0, 1'b1, CMD_ENQ,  8'd10, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 8'd0,  1'b1, 1'b1, CMD_DEQ,  8'd0,  1'b1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 8'd0,  1'b1, 1'b1, CMD_DEQ,  8'd0,  1'b1, 1'b1, 1'b1, 8'd11};
    tbl[7]  = '{1'b0, 8'd0,  1'b1, 1'b1, CMD_DEQ,  8'd0,  1'b1, 1'b1, 1'b1, 8'd10};
    tbl[8]  = '{1'b0, 8'd0,  1'b1, 1'b1, CMD_DEQ,  8'd0,  1'b1, 1'b1, 1'b1, 8'd9};
    tbl[9]  = '{1'b0, 8'd0,  1'b0, 1'b1, CMD_NONE, 8'd0,  1'b1, 1'b0, 1'b1, 8'd8};
    tbl[10] = '{1'b0, 8'd0,  1'b0, 1'b1, CMD_NONE, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0};

    @(negedge clk);
    resetDut();

    // Basic order: four enqueues then four dequeues, max key first.
    for (int r = 0; r < 11; r++) begin
      applyStimulus(tbl[r].ev, tbl[r].ek, tbl[r].dv, tbl[r].rr, 1'b0);
      check("tbl_cmd", int'(bus.pq_cmd), int'(tbl[r].cmd));
      check("tbl_kvi_key", int'(bus.pq_kvi.key), int'(tbl[r].kvi));
      check("tbl_enq_ready", int'(bus.enq_ready), int'(tbl[r].enq_rdy));
      check("tbl_deq_ready", int'(bus.deq_ready), int'(tbl[r].deq_rdy));
      check("tbl_res_valid", int'(bus.res_valid), int'(tbl[r].rv));
      if (tbl[r].rv) check("tbl_res_key", int'(bus.res_kv.key), int'(tbl[r].rkey));
      clockEdge();
    end

    // Fusion: PQ {8,9}, FIFO {1}, then a dequeue becomes one REPL.
    run(1, 8'd8, 0, 1, 0); clockEdge();
    run(1, 8'd9, 0, 1, 0); clockEdge();
    run(0, 8'd0, 0, 1, 0); clockEdge();
    run(1, 8'd1, 0, 1, 0); clockEdge();
    run(0, 8'd0, 1, 1, 0);
    check("fuse_cmd", int'(bus.pq_cmd), int'(CMD_REPL));
    check("fuse_kvi_key", int'(bus.pq_kvi.key), 1);
    clockEdge();
    run(0, 8'd0, 0, 1, 0);
    check("fuse_res_key", int'(bus.res_kv.key), 9);
    clockEdge();
    run(0, 8'd0, 1, 1, 0); clockEdge();
    run(0, 8'd0, 1, 1, 0);
    check("fuse_rest_1", int'(bus.res_kv.key), 8);
    clockEdge();
    run(0, 8'd0, 0, 1, 0);
    check("fuse_rest_2", int'(bus.res_kv.key), 1);
    clockEdge();
    run(0, 8'd0, 0, 1, 0); clockEdge();

    // Empty PQ: dequeue stalls until 23 arrives.
    run(0, 8'd0, 1, 1, 0);
    check("empty_stall_cmd", int'(bus.pq_cmd), int'(CMD_NONE));
    check("empty_stall_deq_ready", int'(bus.deq_ready), 0);
    clockEdge();
    run(1, 8'd23, 1, 1, 0); clockEdge();
    run(0, 8'd0, 1, 1, 0);
    check("empty_enq_cmd", int'(bus.pq_cmd), int'(CMD_ENQ));
    check("empty_enq_key", int'(bus.pq_kvi.key), 23);
    clockEdge();
    run(0, 8'd0, 1, 1, 0);
    check("empty_deq_cmd", int'(bus.pq_cmd), int'(CMD_DEQ));
    clockEdge();
    run(0, 8'd0, 0, 1, 0);
    check("empty_res_key", int'(bus.res_kv.key), 23);
    clockEdge();
    run(0, 8'd0, 0, 1, 0); clockEdge();

    // Backpressure: PQ full and FIFO full, then REPL frees a FIFO slot.
    for (int i = 0; i < 9; i++) begin
      run(1, 8'(20 + i), 0, 1, 0);
      if (i == 8) check("bp_enq_ready_full", int'(bus.enq_ready), 0);
      clockEdge();
    end
    run(0, 8'd0, 1, 0, 0);
    check("bp_repl_cmd", int'(bus.pq_cmd), int'(CMD_REPL));
    clockEdge();
    run(0, 8'd0, 1, 0, 0);
    check("bp_enq_ready_back", int'(bus.enq_ready), 1);
    check("bp_deq_pending", int'(bus.deq_ready), 0);
    check("bp_cmd_hold", int'(bus.pq_cmd), int'(CMD_NONE));
    clockEdge();
    for (int i = 0; i < 14; i++) begin run(0, 8'd0, 1, 1, 0); clockEdge(); end
    run(0, 8'd0, 0, 1, 0); clockEdge();
    run(0, 8'd0, 0, 1, 0); clockEdge();

    // Flush: PQ {23,5}, FIFO {17}; results 23, 17, 5 then back to RUN.
    run(1, 8'd23, 0, 1, 0); clockEdge();
    run(1, 8'd5, 0, 1, 0); clockEdge();
    run(0, 8'd0, 0, 1, 0); clockEdge();
    fd_count = 0;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      run((i == 0), 8'd17, 0, 1, (i == 0 || i == 3));
      if (i >= 1 && i <= 4) check("flush_enq_ready", int'(bus.enq_ready), 0);
      if (bus.res_valid) got.push_back(bus.res_kv.key);
      if (bus.flush_done) fd_count++;
      clockEdge();
    end
    check("flush_done_count", fd_count, 1);
    check("flush_res_count", got.size(), 3);
    if (got.size() == 3) begin
      check("flush_res_0", int'(got[0]), 23);
      check("flush_res_1", int'(got[1]), 17);
      check("flush_res_2", int'(got[2]), 5);
    end
    run(1, 8'd3, 0, 1, 0);
    check("flush_back_run", int'(bus.enq_ready), 1);
    clockEdge();

    // Randomised traffic with a mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) resetDut();
      run(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
          ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 3));
      clockEdge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
